instr_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the registered control decoder. It holds the PC and drives a req/ready instruction-memory port. It captures each 8-bit instruction into an instruction register (IR) and presents the decoded fields: the 2-bit opcode feeds the control unit's 2-bit opcode input, and the register fields and immediate feed the datapath. It also handles stall and branch redirect/flush.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_fetch_pc_reg.sv | 33 +++
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and the
// fetch-stage state encoding used by both the fetch stage and the control unit.
package cpu_pkg;

    localparam logic [1:0] OP_RTYPE  = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 2;
    localparam int RD_MSB = 1;
    localparam int RD_LSB = 0;

    localparam logic [7:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async active-low reset, redirect load, increment or hold.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Clear_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_val,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // PC update; a redirect load takes priority over the post-fetch increment.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, req/ready memory port, instruction register,
// decoded fields for the control unit and datapath, stall and branch flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               Clk,
    input  logic               Clear_n,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [1:0]         op,
    output logic [1:0]         rs,
    output logic [1:0]         rt,
    output logic [1:0]         rd,
    output logic [PC_W-1:0]    imm,
    output logic               ir_valid,
    output logic [PC_W-1:0]    ir_pc,
    output logic [PC_W-1:0]    pc_plus1
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [INSTR_W-1:0] r_ir;
    logic               r_ir_valid;
    logic [PC_W-1:0]    r_ir_pc;
    logic [PC_W-1:0]    w_pc;
    logic               w_req;
    logic               w_xfer;

    assign w_req  = (r_state == ST_FETCH) && !Stall && !BranchTaken;
    assign w_xfer = w_req && imem_ready;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .Clk        (Clk),
        .Clear_n    (Clear_n),
        .i_load     (BranchTaken),
        .i_load_val (BranchTarget),
        .i_inc      (w_xfer),
        .o_pc       (w_pc)
    );

    // State register.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a redirect always lands in FLUSH; IDLE and FLUSH last one cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (BranchTaken) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_FETCH;
                ST_FETCH: w_state_nxt = ST_FETCH;
                ST_FLUSH: w_state_nxt = ST_FETCH;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Instruction register: squash on redirect, load on transfer, bubble on a missed fetch.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_ir       <= {INSTR_W{1'b0}};
            r_ir_valid <= 1'b0;
            r_ir_pc    <= {PC_W{1'b0}};
        end else if (BranchTaken) begin
            r_ir       <= {INSTR_W{1'b0}};
            r_ir_valid <= 1'b0;
            r_ir_pc    <= r_ir_pc;
        end else if (w_xfer) begin
            r_ir       <= imem_rdata;
            r_ir_valid <= 1'b1;
            r_ir_pc    <= w_pc;
        end else if ((r_state == ST_FETCH) && !Stall) begin
            r_ir       <= r_ir;
            r_ir_valid <= 1'b0;
            r_ir_pc    <= r_ir_pc;
        end else begin
            r_ir       <= r_ir;
            r_ir_valid <= r_ir_valid;
            r_ir_pc    <= r_ir_pc;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = w_pc;
    assign op        = r_ir[OP_MSB:OP_LSB];
    assign rs        = r_ir[RS_MSB:RS_LSB];
    assign rt        = r_ir[RT_MSB:RT_LSB];
    assign rd        = r_ir[RD_MSB:RD_LSB];
    assign imm       = {{(PC_W-2){r_ir[RD_MSB]}}, r_ir[RD_MSB:RD_LSB]};
    assign ir_valid  = r_ir_valid;
    assign ir_pc     = r_ir_pc;
    assign pc_plus1  = r_ir_pc + {{(PC_W-1){1'b0}}, 1'b1};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transfer scoreboard and a memory model.
module tb_instr_fetch;

    logic       Clk;
    logic       Clear_n;
    logic       Stall;
    logic       BranchTaken;
    logic [7:0] BranchTarget;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready;
    logic [7:0] imem_rdata;
    logic [1:0] op, rs, rt, rd;
    logic [7:0] imm;
    logic       ir_valid;
    logic [7:0] ir_pc;
    logic [7:0] pc_plus1;

    logic [7:0]  mem [256];
    logic [15:0] sb [$];
    int total = 0;
    int bad   = 0;

    instr_fetch #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .Clk          (Clk),
        .Clear_n      (Clear_n),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm          (imm),
        .ir_valid     (ir_valid),
        .ir_pc        (ir_pc),
        .pc_plus1     (pc_plus1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record a transfer if one is about to happen, then score it after the edge.
    task automatic tick();
        logic       xfer;
        logic [15:0] e;
        logic [7:0] ins, adr;
        #1;
        xfer = imem_req && imem_ready;
        if (xfer) sb.push_back({imem_rdata, imem_addr});
        @(posedge Clk);
        #1;
        if (xfer) begin
            e   = sb.pop_front();
            ins = e[15:8];
            adr = e[7:0];
            chk("sb_op",    32'(op),       32'(ins[7:6]));
            chk("sb_rs",    32'(rs),       32'(ins[5:4]));
            chk("sb_rt",    32'(rt),       32'(ins[3:2]));
            chk("sb_rd",    32'(rd),       32'(ins[1:0]));
            chk("sb_imm",   32'(imm),      32'({{6{ins[1]}}, ins[1:0]}));
            chk("sb_irpc",  32'(ir_pc),    32'(adr));
            chk("sb_pcp1",  32'(pc_plus1), 32'(8'(adr + 8'd1)));
            chk("sb_valid", 32'(ir_valid), 32'd1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req),  32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'h00);
        chk({tag, "_valid"}, 32'(ir_valid),  32'd0);
        chk({tag, "_op"},    32'({op, rs, rt, rd}), 32'h00);
        chk({tag, "_imm"},   32'(imm),       32'h00);
        chk({tag, "_irpc"},  32'(ir_pc),     32'h00);
        chk({tag, "_pcp1"},  32'(pc_plus1),  32'h01);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h5B;
        mem[1] = 8'hC6;
        mem[2] = 8'h1F;
        Clear_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
        BranchTarget = 8'h00; imem_ready = 1'b1;

        #2;
        chk_reset_outputs("reset");

        // Release reset: one IDLE cycle without a request, then fetch from 0.
        @(negedge Clk);
        Clear_n = 1'b1;
        #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("fetch0_req",  32'(imem_req),  32'd1);
        chk("fetch0_addr", 32'(imem_addr), 32'h00);
        tick();
        chk("first_op",   32'(op),       32'h1);
        chk("first_rs",   32'(rs),       32'h1);
        chk("first_rt",   32'(rt),       32'h2);
        chk("first_rd",   32'(rd),       32'h3);
        chk("first_imm",  32'(imm),      32'hFF);
        chk("first_irpc", 32'(ir_pc),    32'h00);
        chk("first_pcp1", 32'(pc_plus1), 32'h01);
        chk("first_addr", 32'(imem_addr), 32'h01);
        tick();
        chk("second_addr", 32'(imem_addr), 32'h02);

        // Stall with IR=C6 for three cycles.
        Stall = 1'b1;
        #1;
        chk("stall_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_req_h", 32'(imem_req),  32'd0);
            chk("stall_ir",    32'({op, rs, rt, rd}), 32'hC6);
            chk("stall_irpc",  32'(ir_pc),     32'h01);
            chk("stall_valid", 32'(ir_valid),  32'd1);
            chk("stall_pc",    32'(imem_addr), 32'h02);
        end
        Stall = 1'b0;
        #1;
        chk("resume_req",  32'(imem_req),  32'd1);
        chk("resume_addr", 32'(imem_addr), 32'h02);
        tick();

        // Branch beats Stall and ready.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 8'h40; imem_ready = 1'b1;
        #1;
        chk("br_req", 32'(imem_req), 32'd0);
        tick();
        Stall = 1'b0; BranchTaken = 1'b0;
        #1;
        chk("flush_valid", 32'(ir_valid),  32'd0);
        chk("flush_ir",    32'({op, rs, rt, rd}), 32'h00);
        chk("flush_req",   32'(imem_req),  32'd0);
        chk("flush_addr",  32'(imem_addr), 32'h40);
        tick();
        chk("after_flush_req",  32'(imem_req),  32'd1);
        chk("after_flush_addr", 32'(imem_addr), 32'h40);

        // Memory not ready for two cycles.
        imem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("wait_req",   32'(imem_req),  32'd1);
            chk("wait_addr",  32'(imem_addr), 32'h40);
            chk("wait_valid", 32'(ir_valid),  32'd0);
        end
        imem_ready = 1'b1;
        tick();
        chk("wait_done_irpc", 32'(ir_pc), 32'h40);

        // PC wrap at 8'hFF.
        BranchTaken = 1'b1; BranchTarget = 8'hFF;
        tick();
        BranchTaken = 1'b0;
        tick();
        chk("wrap_pre_addr", 32'(imem_addr), 32'hFF);
        tick();
        chk("wrap_addr", 32'(imem_addr), 32'h00);
        chk("wrap_pcp1", 32'(pc_plus1),  32'h00);

        // Reset asserted mid-wait.
        imem_ready = 1'b0;
        tick();
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        #2;
        Clear_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge Clk);
        Clear_n = 1'b1; imem_ready = 1'b1;
        #1;
        chk("rst_idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("rst_fetch_req",  32'(imem_req),  32'd1);
        chk("rst_fetch_addr", 32'(imem_addr), 32'h00);
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
